// File: rtl/lsq_forward_queue.sv
// lsq_forward_queue: split load and store circular queues with full word-address
// comparison. Loads bypass older non-matching stores, take store-to-load
// forwarding when the youngest matching older store covers all their bytes, and
// wait on partial overlaps. Stores drain to memory only after commit.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready/in_*     request push (in_load selects queue)
//   store_commit               marks oldest uncommitted store committed
//   flush                      drops all loads and uncommitted stores
//   mem_valid/mem_ready/mem_*  single memory request port (load or store)
//   fwd_valid/fwd_id/fwd_data  forwarded load result, single cycle
//   lq_empty, sq_empty         queue status
module lsq_forward_queue #(
   parameter int unsigned LQ_DEPTH = 4,
   parameter int unsigned SQ_DEPTH = 4,
   parameter int unsigned ID_W     = 3,
   parameter int unsigned ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_load,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [3:0]        in_be,
   input  logic [31:0]       in_data,
   input  logic [ID_W-1:0]   in_id,
   input  logic              store_commit,
   input  logic              flush,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_rnw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_data,
   output logic [ID_W-1:0]   mem_id,
   output logic              fwd_valid,
   output logic [ID_W-1:0]   fwd_id,
   output logic [31:0]       fwd_data,
   output logic              lq_empty,
   output logic              sq_empty
);
   localparam int unsigned LQ_AW = $clog2(LQ_DEPTH);
   localparam int unsigned SQ_AW = $clog2(SQ_DEPTH);
   localparam int unsigned LQ_PW = LQ_AW + 1;
   localparam int unsigned SQ_PW = SQ_AW + 1;

   // Queue storage; entry validity is implied by the pointers
   logic [ADDR_W-1:0]   lq_addr  [LQ_DEPTH];
   logic [3:0]          lq_be    [LQ_DEPTH];
   logic [ID_W-1:0]     lq_id    [LQ_DEPTH];
   logic [SQ_DEPTH-1:0] lq_older [LQ_DEPTH];
   logic [SQ_AW-1:0]    lq_snap  [LQ_DEPTH];
   logic [ADDR_W-1:0]   sq_addr  [SQ_DEPTH];
   logic [3:0]          sq_be    [SQ_DEPTH];
   logic [31:0]         sq_data  [SQ_DEPTH];

   logic [LQ_PW-1:0] lq_head, lq_tail, lq_head_nxt;
   logic [SQ_PW-1:0] sq_head, sq_cmt, sq_tail, sq_cmt_nxt, sq_cnt;
   logic [LQ_AW-1:0] lq_hidx, lq_tidx;
   logic [SQ_AW-1:0] sq_hidx, sq_tidx, sq_off, hit_idx, srch_idx;
   logic [SQ_DEPTH-1:0] sq_live, st_pop_mask;
   logic lq_full, sq_full, st_head_cmt, cmt_ok;
   logic ld_push, st_push, ld_pop, st_pop;
   logic hit, covers, ld_mem_ok, ld_fwd;
   logic [31:0] ld_mask;

   assign lq_hidx = lq_head[LQ_AW-1:0];
   assign lq_tidx = lq_tail[LQ_AW-1:0];
   assign sq_hidx = sq_head[SQ_AW-1:0];
   assign sq_tidx = sq_tail[SQ_AW-1:0];

   // Status and acceptance from registered pointers only
   assign lq_full     = (lq_head ^ lq_tail) == {1'b1, {LQ_AW{1'b0}}};
   assign sq_full     = (sq_head ^ sq_tail) == {1'b1, {SQ_AW{1'b0}}};
   assign lq_empty    = (lq_head == lq_tail);
   assign sq_empty    = (sq_head == sq_tail);
   assign st_head_cmt = (sq_head != sq_cmt);
   assign cmt_ok      = store_commit && (sq_cmt != sq_tail);
   assign in_ready    = !flush && (in_load ? !lq_full : !sq_full);
   assign ld_push     = in_valid && in_ready && in_load;
   assign st_push     = in_valid && in_ready && !in_load;

   // Occupied store slots, used as the older-store snapshot of a new load
   always_comb begin
      sq_cnt  = sq_tail - sq_head;
      sq_live = '0;
      sq_off  = '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
         sq_off     = SQ_AW'(i) - sq_hidx;
         sq_live[i] = {1'b0, sq_off} < sq_cnt;
      end
   end

   // Youngest older matching store: walk back from the load's tail snapshot;
   // descending k lets the nearest slot overwrite the earlier matches
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      srch_idx = '0;
      for (int k = SQ_DEPTH - 1; k >= 0; k--) begin
         srch_idx = lq_snap[lq_hidx] - SQ_AW'(k + 1);
         if (lq_older[lq_hidx][srch_idx] &&
             (sq_addr[srch_idx][ADDR_W-1:2] == lq_addr[lq_hidx][ADDR_W-1:2])) begin
            hit     = 1'b1;
            hit_idx = srch_idx;
         end
      end
   end

   assign covers    = (lq_be[lq_hidx] & ~sq_be[hit_idx]) == 4'b0;
   assign ld_mem_ok = !lq_empty && !hit;
   assign ld_fwd    = !lq_empty && hit && covers && !flush;
   assign ld_mask   = {{8{lq_be[lq_hidx][3]}}, {8{lq_be[lq_hidx][2]}},
                       {8{lq_be[lq_hidx][1]}}, {8{lq_be[lq_hidx][0]}}};

   // Memory port: issuable load first, else committed store head
   always_comb begin
      mem_valid = 1'b0;
      mem_rnw   = 1'b0;
      mem_addr  = '0;
      mem_be    = '0;
      mem_data  = '0;
      mem_id    = '0;
      if (ld_mem_ok) begin
         mem_valid = 1'b1;
         mem_rnw   = 1'b1;
         mem_addr  = lq_addr[lq_hidx];
         mem_be    = lq_be[lq_hidx];
         mem_id    = lq_id[lq_hidx];
      end else if (st_head_cmt) begin
         mem_valid = 1'b1;
         mem_addr  = sq_addr[sq_hidx];
         mem_be    = sq_be[sq_hidx];
         mem_data  = sq_data[sq_hidx];
      end
   end

   assign fwd_valid = ld_fwd;
   assign fwd_id    = ld_fwd ? lq_id[lq_hidx] : '0;
   assign fwd_data  = ld_fwd ? (sq_data[hit_idx] & ld_mask) : '0;

   assign ld_pop = ld_fwd || (ld_mem_ok && mem_ready);
   assign st_pop = !ld_mem_ok && st_head_cmt && mem_ready;

   always_comb begin
      st_pop_mask = '0;
      if (st_pop) st_pop_mask[sq_hidx] = 1'b1;
   end

   assign lq_head_nxt = lq_head + LQ_PW'(ld_pop);
   assign sq_cmt_nxt  = sq_cmt + SQ_PW'(cmt_ok);

   // Pointers; flush collapses LQ and rewinds SQ tail to the commit point
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lq_head <= '0;
         lq_tail <= '0;
         sq_head <= '0;
         sq_cmt  <= '0;
         sq_tail <= '0;
      end else begin
         lq_head <= lq_head_nxt;
         lq_tail <= flush ? lq_head_nxt : lq_tail + LQ_PW'(ld_push);
         sq_head <= sq_head + SQ_PW'(st_pop);
         sq_cmt  <= sq_cmt_nxt;
         sq_tail <= flush ? sq_cmt_nxt : sq_tail + SQ_PW'(st_push);
      end
   end

   // Entry payloads; an issuing store drops out of every load's older set
   always_ff @(posedge clk) begin
      if (st_pop) begin
         for (int i = 0; i < LQ_DEPTH; i++) lq_older[i][sq_hidx] <= 1'b0;
      end
      if (ld_push) begin
         lq_addr[lq_tidx]  <= in_addr;
         lq_be[lq_tidx]    <= in_be;
         lq_id[lq_tidx]    <= in_id;
         lq_older[lq_tidx] <= sq_live & ~st_pop_mask;
         lq_snap[lq_tidx]  <= sq_tidx;
      end
      if (st_push) begin
         sq_addr[sq_tidx] <= in_addr;
         sq_be[sq_tidx]   <= in_be;
         sq_data[sq_tidx] <= in_data;
      end
   end

   // Commit with nothing left to commit is dropped by the pointer logic
   assert property (@(posedge clk) disable iff (!rst_n) store_commit |-> (sq_cmt != sq_tail));

endmodule

// File: tb/tb_lsq_forward_queue.sv
module tb_lsq_forward_queue;
   localparam int unsigned DEPTH = 4;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_load;
   logic [31:0] in_addr, in_data;
   logic [3:0]  in_be;
   logic [2:0]  in_id;
   logic        store_commit, flush;
   logic        mem_valid, mem_ready, mem_rnw;
   logic [31:0] mem_addr, mem_data;
   logic [3:0]  mem_be;
   logic [2:0]  mem_id;
   logic        fwd_valid;
   logic [2:0]  fwd_id;
   logic [31:0] fwd_data;
   logic        lq_empty, sq_empty;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lsq_forward_queue #(.LQ_DEPTH(DEPTH), .SQ_DEPTH(DEPTH), .ID_W(3), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
      .in_addr(in_addr), .in_be(in_be), .in_data(in_data), .in_id(in_id),
      .store_commit(store_commit), .flush(flush),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rnw(mem_rnw),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_data(mem_data), .mem_id(mem_id),
      .fwd_valid(fwd_valid), .fwd_id(fwd_id), .fwd_data(fwd_data),
      .lq_empty(lq_empty), .sq_empty(sq_empty)
   );

   typedef struct {
      logic iv; logic ld; logic [31:0] addr; logic [3:0] be; logic [31:0] data; logic [2:0] id;
      logic cmt; logic fl; logic mr;
      logic e_mv; logic e_rnw; logic [31:0] e_maddr; logic [31:0] e_mdata;
      logic e_fv; logic [31:0] e_fdata; logic e_lqe; logic e_sqe; logic e_rdy;
   } vec_t;

   localparam int NV = 32;
   vec_t vt [NV];

   // Reference model: program-ordered store list with global ages
   typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] data; int uid; } st_t;
   typedef struct { logic [31:0] addr; logic [3:0] be; logic [2:0] id; int lim; } ld_t;
   st_t sq_m[$];
   ld_t lq_m[$];
   int  n_cmt, uid_next;
   logic e_rdy, e_mv, e_rnw, e_fv;
   logic [31:0] e_maddr, e_mdata, e_fdata;
   logic [3:0]  e_mbe;
   logic [2:0]  e_mid, e_fid;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic ld, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] d, input logic [2:0] id, input logic cm, input logic fl,
                        input logic mr);
      in_valid = iv; in_load = ld; in_addr = a; in_be = be; in_data = d; in_id = id;
      store_commit = cm; flush = fl; mem_ready = mr;
   endtask

   function automatic logic [31:0] bmask(input logic [3:0] be);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
      return m;
   endfunction

   task automatic model_eval();
      int best;
      logic [29:0] wa, wb;
      e_rdy = !flush && (in_load ? (lq_m.size() < DEPTH) : (sq_m.size() < DEPTH));
      e_mv = 1'b0; e_rnw = 1'b0; e_fv = 1'b0;
      e_maddr = '0; e_mdata = '0; e_fdata = '0; e_mbe = '0; e_mid = '0; e_fid = '0;
      if (lq_m.size() > 0) begin
         best = -1;
         wa = lq_m[0].addr[31:2];
         for (int j = 0; j < sq_m.size(); j++) begin
            wb = sq_m[j].addr[31:2];
            if (sq_m[j].uid < lq_m[0].lim && wa == wb) best = j;
         end
         if (best < 0) begin
            e_mv = 1'b1; e_rnw = 1'b1; e_maddr = lq_m[0].addr; e_mbe = lq_m[0].be; e_mid = lq_m[0].id;
         end else if ((lq_m[0].be & ~sq_m[best].be) == 4'b0 && !flush) begin
            e_fv = 1'b1; e_fid = lq_m[0].id; e_fdata = sq_m[best].data & bmask(lq_m[0].be);
         end
      end
      if (!e_mv && n_cmt > 0) begin
         e_mv = 1'b1; e_maddr = sq_m[0].addr; e_mbe = sq_m[0].be; e_mdata = sq_m[0].data;
      end
   endtask

   task automatic model_step();
      ld_t nl;
      st_t ns;
      if (store_commit && n_cmt < sq_m.size()) n_cmt++;
      if (e_mv && mem_ready) begin
         if (e_rnw) void'(lq_m.pop_front());
         else begin void'(sq_m.pop_front()); n_cmt--; end
      end
      if (e_fv) void'(lq_m.pop_front());
      if (in_valid && e_rdy) begin
         if (in_load) begin
            nl.addr = in_addr; nl.be = in_be; nl.id = in_id; nl.lim = uid_next;
            lq_m.push_back(nl);
         end else begin
            ns.addr = in_addr; ns.be = in_be; ns.data = in_data; ns.uid = uid_next;
            uid_next++;
            sq_m.push_back(ns);
         end
      end
      if (flush) begin
         lq_m.delete();
         while (sq_m.size() > n_cmt) void'(sq_m.pop_back());
      end
   endtask

   task automatic chk_idle_reset(input string tag);
      chk({tag, " mem_valid"}, 32'(mem_valid), 32'(0));
      chk({tag, " fwd_valid"}, 32'(fwd_valid), 32'(0));
      chk({tag, " lq_empty"},  32'(lq_empty),  32'(1));
      chk({tag, " sq_empty"},  32'(sq_empty),  32'(1));
      chk({tag, " in_ready"},  32'(in_ready),  32'(1));
   endtask

   initial begin
      //      iv ld addr        be     data          id    cm fl mr  mv rnw maddr       mdata         fv fdata         lqe sqe rdy
      vt[0]  = '{H,L,32'h100,4'hF,32'hAABBCCDD,3'd0, L,L,H, L,L,32'h0,  32'h0,        L,32'h0,        H,H,H};
      vt[1]  = '{H,H,32'h200,4'hF,32'h0,       3'd1, L,L,H, L,L,32'h0,  32'h0,        L,32'h0,        H,L,H};
      vt[2]  = '{L,L,32'h0,  4'h0,32'h0,       3'd0, L,L,H, H,H,32'h200,32'h0,        L,32'h0,        L,L,H};
      vt[3]  = '{L,L,32'h0,  4'h0,32'h0,       3'd0, H,L,L, L,L,32'h0,  32'h0,        L,32'h0,        H,L,H};
      vt[4]  = '{L,L,32'h0,  4'h0,32'h0,       3'd0, L,L,H, H,L,32'h100,32'hAABBCCDD, L,32'h0,        H,L,H};
      vt[5]  = '{H,L,32'h104,4'hF,32'h11223344,3'd0, L,L,H, L,L,32'h0,  32'h0,        L,32'h0,        H,H,H};
      vt[6]  = '{H,H,32'h106,4'hC,32'h0,       3'd2, L,L,H, L,L,32'h0,  32'h0,        L,32'h0,        H,L,H};
      vt[7]  = '{L,L,32'h0,  4'h0,32'h0,       3'd0, L,L,H, L,L,32'h0,  32'h0,        H,32'h11220000, L,L,H};
      vt[8]  = '{L,L,32'h0,  4'h0,32'h0,       3'd0, H,L,H, L,L,32'h0,  32'h0,        L,32'h0,        H,L,H};
      vt[9]  = '{L,L,32'h0,  4'h0,32'h0,       3'd0, L,L,H, H,L,32'h104,32'h11223344, L,32'h0,        H,L,H};
      vt[10] = '{H,L,32'h40, 4'hF,32'h1,       3'd0, L,L,L, L,L,32'h0,  32'h0,        L,32'h0,        H,H,H};
      vt[11] = '{H,L,32'h40, 4'hF,32'h2,       3'd0, L,L,L, L,L,32'h0,  32'h0,        L,32'h0,        H,L,H};
      vt[12] = '{H,H,32'h40, 4'hF,32'h0,       3'd3, L,L,L, L,L,32'h0,  32'h0,        L,32'h0,        H,L,H};
      vt[13] = '{L,L,32'h0,  4'h0,32'h0,       3'd0, L,L,L, L,L,32'h0,  32'h0,        H,32'h2,        L,L,H};
      vt[14] = '{L,L,32'h0,  4'h0,32'h0,       3'd0, H,L,L, L,L,32'h0,  32'h0,        L,32'h0,        H,L,H};
      vt[15] = '{L,L,32'h0,  4'h0,32'h0,       3'd0, H,L,H, H,L,32'h40, 32'h1,        L,32'h0,        H,L,H};
      vt[16] = '{L,L,32'h0,  4'h0,32'h0,       3'd0, L,L,H, H,L,32'h40, 32'h2,        L,32'h0,        H,L,H};
      vt[17] = '{H,L,32'h80, 4'h3,32'h55667788,3'd0, L,L,H, L,L,32'h0,  32'h0,        L,32'h0,        H,H,H};
      vt[18] = '{H,H,32'h80, 4'hF,32'h0,       3'd4, L,L,H, L,L,32'h0,  32'h0,        L,32'h0,        H,L,H};
      vt[19] = '{L,L,32'h0,  4'h0,32'h0,       3'd0, L,L,H, L,L,32'h0,  32'h0,        L,32'h0,        L,L,H};
      vt[20] = '{L,L,32'h0,  4'h0,32'h0,       3'd0, H,L,H, L,L,32'h0,  32'h0,        L,32'h0,        L,L,H};
      vt[21] = '{L,L,32'h0,  4'h0,32'h0,       3'd0, L,L,H, H,L,32'h80, 32'h55667788, L,32'h0,        L,L,H};
      vt[22] = '{L,L,32'h0,  4'h0,32'h0,       3'd0, L,L,H, H,H,32'h80, 32'h0,        L,32'h0,        L,H,H};
      vt[23] = '{H,L,32'h300,4'hF,32'h30,      3'd0, L,L,L, L,L,32'h0,  32'h0,        L,32'h0,        H,H,H};
      vt[24] = '{H,L,32'h304,4'hF,32'h31,      3'd0, H,L,L, L,L,32'h0,  32'h0,        L,32'h0,        H,L,H};
      vt[25] = '{H,L,32'h308,4'hF,32'h32,      3'd0, H,L,L, H,L,32'h300,32'h30,       L,32'h0,        H,L,H};
      vt[26] = '{H,L,32'h30C,4'hF,32'h33,      3'd0, L,L,L, H,L,32'h300,32'h30,       L,32'h0,        H,L,H};
      vt[27] = '{H,L,32'h310,4'hF,32'h34,      3'd0, L,L,L, H,L,32'h300,32'h30,       L,32'h0,        H,L,L};
      vt[28] = '{L,L,32'h0,  4'h0,32'h0,       3'd0, L,H,L, H,L,32'h300,32'h30,       L,32'h0,        H,L,L};
      vt[29] = '{L,L,32'h0,  4'h0,32'h0,       3'd0, L,L,H, H,L,32'h300,32'h30,       L,32'h0,        H,L,H};
      vt[30] = '{L,L,32'h0,  4'h0,32'h0,       3'd0, L,L,H, H,L,32'h304,32'h31,       L,32'h0,        H,L,H};
      vt[31] = '{L,L,32'h0,  4'h0,32'h0,       3'd0, L,L,L, L,L,32'h0,  32'h0,        L,32'h0,        H,H,H};

      rst_n = 1'b0;
      drive(L, L, 32'h0, 4'h0, 32'h0, 3'd0, L, L, L);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk_idle_reset("reset");
      rst_n = 1'b1;

      // Directed scenarios, one row per cycle
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vt[i].iv, vt[i].ld, vt[i].addr, vt[i].be, vt[i].data, vt[i].id, vt[i].cmt, vt[i].fl, vt[i].mr);
         #1;
         chk($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(vt[i].e_rdy));
         chk($sformatf("v%0d mem_valid", i), 32'(mem_valid), 32'(vt[i].e_mv));
         chk($sformatf("v%0d fwd_valid", i), 32'(fwd_valid), 32'(vt[i].e_fv));
         chk($sformatf("v%0d lq_empty", i),  32'(lq_empty),  32'(vt[i].e_lqe));
         chk($sformatf("v%0d sq_empty", i),  32'(sq_empty),  32'(vt[i].e_sqe));
         if (vt[i].e_mv) begin
            chk($sformatf("v%0d mem_rnw", i),  32'(mem_rnw), 32'(vt[i].e_rnw));
            chk($sformatf("v%0d mem_addr", i), mem_addr, vt[i].e_maddr);
            if (!vt[i].e_rnw) chk($sformatf("v%0d mem_data", i), mem_data, vt[i].e_mdata);
         end
         if (vt[i].e_fv) chk($sformatf("v%0d fwd_data", i), fwd_data, vt[i].e_fdata);
      end

      // Reset mid-operation: 3 stores and 2 loads queued, memory stalled
      @(negedge clk); drive(H, L, 32'h500, 4'hF, 32'h50, 3'd0, L, L, L);
      @(negedge clk); drive(H, L, 32'h504, 4'hF, 32'h51, 3'd0, L, L, L);
      @(negedge clk); drive(H, L, 32'h508, 4'hF, 32'h52, 3'd0, L, L, L);
      @(negedge clk); drive(H, H, 32'h600, 4'hF, 32'h0,  3'd5, L, L, L);
      @(negedge clk); drive(H, H, 32'h604, 4'hF, 32'h0,  3'd6, L, L, L);
      @(negedge clk); drive(L, L, 32'h0, 4'h0, 32'h0, 3'd0, L, L, L);
      #1;
      chk("midrst pre lq_empty", 32'(lq_empty), 32'(0));
      chk("midrst pre sq_empty", 32'(sq_empty), 32'(0));
      chk("midrst pre mem_valid", 32'(mem_valid), 32'(1));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_idle_reset("midrst");
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic against the queue-level model
      sq_m.delete(); lq_m.delete(); n_cmt = 0; uid_next = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         logic cm;
         @(negedge clk);
         cm = (n_cmt < sq_m.size()) && ($urandom_range(0, 9) < 3);
         drive($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
               32'h40 + 32'($urandom_range(0, 3)) * 32'd4 + 32'($urandom_range(0, 3)),
               4'($urandom_range(1, 15)), $urandom, 3'($urandom_range(0, 7)),
               cm, $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 6);
         #1;
         model_eval();
         chk($sformatf("r%0d in_ready", cyc),  32'(in_ready),  32'(e_rdy));
         chk($sformatf("r%0d mem_valid", cyc), 32'(mem_valid), 32'(e_mv));
         chk($sformatf("r%0d fwd_valid", cyc), 32'(fwd_valid), 32'(e_fv));
         chk($sformatf("r%0d lq_empty", cyc),  32'(lq_empty),  32'(lq_m.size() == 0));
         chk($sformatf("r%0d sq_empty", cyc),  32'(sq_empty),  32'(sq_m.size() == 0));
         if (e_mv) begin
            chk($sformatf("r%0d mem_rnw", cyc),  32'(mem_rnw), 32'(e_rnw));
            chk($sformatf("r%0d mem_addr", cyc), mem_addr, e_maddr);
            chk($sformatf("r%0d mem_be", cyc),   32'(mem_be), 32'(e_mbe));
            chk($sformatf("r%0d mem_id", cyc),   32'(mem_id), 32'(e_mid));
            if (!e_rnw) chk($sformatf("r%0d mem_data", cyc), mem_data, e_mdata);
         end
         if (e_fv) begin
            chk($sformatf("r%0d fwd_id", cyc),   32'(fwd_id), 32'(e_fid));
            chk($sformatf("r%0d fwd_data", cyc), fwd_data, e_fdata);
         end
         @(posedge clk);
         model_step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
